// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Define DCACHE_PERF_CNT_EN to add the hit_cnt_o / miss_cnt_o performance counters.
module dcache_controller #(
   parameter int LINES     = 16,
   parameter int LINE_BITS = 256,
   parameter int TAG_BITS  = 23
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_req_i,
   input  logic                 cpu_we_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [31:0]          cpu_data_i,
   output logic [31:0]          cpu_data_o,
   output logic                 cpu_stall_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
`ifdef DCACHE_PERF_CNT_EN
   input  logic                 mem_ack_i,
   output logic [31:0]          hit_cnt_o,
   output logic [31:0]          miss_cnt_o
`else
   input  logic                 mem_ack_i
`endif
);

   localparam int IDX_BITS = $clog2(LINES);

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE,
      REFILL_DONE
   } state_t;

   state_t                r_state;
   logic [LINES-1:0]      r_valid;
   logic [LINES-1:0]      r_dirty;
   logic [TAG_BITS-1:0]   r_tag  [LINES];
   logic [LINE_BITS-1:0]  r_data [LINES];
   logic                  r_memEnable;
   logic                  r_memWrite;
   logic [31:0]           r_memAddr;
   logic [LINE_BITS-1:0]  r_memData;

   logic [IDX_BITS-1:0]   w_idx;
   logic [TAG_BITS-1:0]   w_tag;
   logic [2:0]            w_word;
   logic                  w_hit;
   logic                  w_unusedAddr;

   assign w_idx        = cpu_addr_i[5+IDX_BITS-1:5];
   assign w_tag        = cpu_addr_i[31:32-TAG_BITS];
   assign w_word       = cpu_addr_i[4:2];
   assign w_unusedAddr = ^cpu_addr_i[1:0];

   assign w_hit       = (r_state == IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign cpu_stall_o = cpu_req_i && !w_hit;
   assign cpu_data_o  = (cpu_req_i && !cpu_we_i && w_hit) ?
                        r_data[w_idx][{w_word, 5'b00000} +: 32] : 32'd0;

   assign mem_enable_o = r_memEnable;
   assign mem_write_o  = r_memWrite;
   assign mem_addr_o   = r_memAddr;
   assign mem_data_o   = r_memData;

   // Control state, valid/dirty bits and the registered memory-side outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= IDLE;
         r_valid     <= '0;
         r_dirty     <= '0;
         r_memEnable <= 1'b0;
         r_memWrite  <= 1'b0;
         r_memAddr   <= '0;
         r_memData   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cpu_req_i && !w_hit) begin
                  r_memEnable <= 1'b1;
                  if (r_valid[w_idx] && r_dirty[w_idx]) begin
                     r_state    <= WRITEBACK;
                     r_memWrite <= 1'b1;
                     r_memAddr  <= {r_tag[w_idx], w_idx, 5'b00000};
                     r_memData  <= r_data[w_idx];
                  end else begin
                     r_state    <= ALLOCATE;
                     r_memWrite <= 1'b0;
                     r_memAddr  <= {cpu_addr_i[31:5], 5'b00000};
                  end
               end else if (cpu_req_i && cpu_we_i) begin
                  r_dirty[w_idx] <= 1'b1;
               end
            end
            WRITEBACK: begin
               if (mem_ack_i) begin
                  r_state    <= ALLOCATE;
                  r_memWrite <= 1'b0;
                  r_memAddr  <= {cpu_addr_i[31:5], 5'b00000};
               end
            end
            ALLOCATE: begin
               if (mem_ack_i) begin
                  r_state        <= REFILL_DONE;
                  r_memEnable    <= 1'b0;
                  r_valid[w_idx] <= 1'b1;
                  r_dirty[w_idx] <= 1'b0;
               end
            end
            REFILL_DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Tag and line storage carry no reset; validity is tracked separately.
   always_ff @(posedge clk_i) begin
      if (r_state == ALLOCATE && mem_ack_i) begin
         r_data[w_idx] <= mem_data_i;
         r_tag[w_idx]  <= w_tag;
      end else if (cpu_req_i && cpu_we_i && w_hit) begin
         r_data[w_idx][{w_word, 5'b00000} +: 32] <= cpu_data_i;
      end
   end

`ifdef DCACHE_PERF_CNT_EN
   logic [31:0] r_hitCnt;
   logic [31:0] r_missCnt;
   logic        r_prevRefill;

   // The hit that completes a refilled miss is not counted as a separate hit.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_hitCnt     <= '0;
         r_missCnt    <= '0;
         r_prevRefill <= 1'b0;
      end else begin
         r_prevRefill <= (r_state == REFILL_DONE);
         if (cpu_req_i && w_hit && !r_prevRefill) begin
            r_hitCnt <= r_hitCnt + 32'd1;
         end
         if (r_state == IDLE && cpu_req_i && !w_hit) begin
            r_missCnt <= r_missCnt + 32'd1;
         end
      end
   end

   assign hit_cnt_o  = r_hitCnt;
   assign miss_cnt_o = r_missCnt;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller; the bench acts as the
// off-chip memory and acknowledges each line transfer after a chosen latency.
module tb_dcache_controller;

   logic         clock;
   logic         resetN;
   logic         cpuReq;
   logic         cpuWe;
   logic [31:0]  cpuAddr;
   logic [31:0]  cpuData;
   logic [31:0]  cpuDataOut;
   logic         cpuStall;
   logic         memEnable;
   logic         memWrite;
   logic [31:0]  memAddr;
   logic [255:0] memDataOut;
   logic [255:0] memDataIn;
   logic         memAck;
`ifdef DCACHE_PERF_CNT_EN
   logic [31:0]  hitCnt;
   logic [31:0]  missCnt;
`endif

   int           checkCount;
   int           passCount;

   int           stallCycles;
   int           nFetch;
   int           nWb;
   logic         addrChanged;
   logic [31:0]  loadData;
   logic [31:0]  fetchAddr;
   logic [31:0]  wbAddr;
   logic [255:0] wbData;
   logic [255:0] fillA;
   logic [255:0] fillB;

   dcache_controller dut (
      .clk_i       (clock),
      .rst_i       (resetN),
      .cpu_req_i   (cpuReq),
      .cpu_we_i    (cpuWe),
      .cpu_addr_i  (cpuAddr),
      .cpu_data_i  (cpuData),
      .cpu_data_o  (cpuDataOut),
      .cpu_stall_o (cpuStall),
      .mem_enable_o(memEnable),
      .mem_write_o (memWrite),
      .mem_addr_o  (memAddr),
      .mem_data_o  (memDataOut),
      .mem_data_i  (memDataIn),
`ifdef DCACHE_PERF_CNT_EN
      .mem_ack_i   (memAck),
      .hit_cnt_o   (hitCnt),
      .miss_cnt_o  (missCnt)
`else
      .mem_ack_i   (memAck)
`endif
   );

   // Free-running 10 ns clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One comparison: counts it, and reports tag/observed/expected on a miscompare.
   task automatic checkOutput(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   // Issues one CPU request, serves memory with the given ack latency, and
   // records stall cycles, transfers and the load data seen in the completing cycle.
   task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input int latency,
                                input logic [255:0] fill);
      int          waitCnt;
      int          cyc;
      logic        done;
      logic [31:0] heldAddr;
      stallCycles = 0;
      nFetch      = 0;
      nWb         = 0;
      addrChanged = 1'b0;
      loadData    = 32'hDEAD_BEEF;
      waitCnt     = 0;
      cyc         = 0;
      done        = 1'b0;
      heldAddr    = '0;
      cpuReq      = 1'b1;
      cpuWe       = we;
      cpuAddr     = addr;
      cpuData     = wdata;
      while (!done && cyc < 200) begin
         @(negedge clock);
         cyc++;
         if (!cpuStall) begin
            done     = 1'b1;
            loadData = cpuDataOut;
         end else begin
            stallCycles++;
            if (memEnable) begin
               waitCnt++;
               if (waitCnt == 1) heldAddr = memAddr;
               else if (memAddr !== heldAddr) addrChanged = 1'b1;
               if (waitCnt == latency) begin
                  memAck = 1'b1;
                  if (memWrite) begin
                     nWb++;
                     wbAddr = memAddr;
                     wbData = memDataOut;
                  end else begin
                     nFetch++;
                     fetchAddr = memAddr;
                     memDataIn = fill;
                  end
                  waitCnt = 0;
               end
            end
         end
         @(posedge clock);
         #1;
         memAck = 1'b0;
      end
      cpuReq = 1'b0;
      cpuWe  = 1'b0;
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      for (int w = 0; w < 8; w++) begin
         fillA[w*32 +: 32] = 32'hA000_0000 | w;
         fillB[w*32 +: 32] = 32'hB000_0000 | w;
      end
      resetN    = 1'b1;
      cpuReq    = 1'b0;
      cpuWe     = 1'b0;
      cpuAddr   = '0;
      cpuData   = '0;
      memDataIn = '0;
      memAck    = 1'b0;
      #1 resetN = 1'b0;

      // Reset state
      @(negedge clock);
      checkOutput("rst_mem_enable", memEnable, 0);
      checkOutput("rst_mem_write", memWrite, 0);
      checkOutput("rst_mem_addr", memAddr, 0);
      checkOutput("rst_mem_data", memDataOut, 0);
      checkOutput("rst_cpu_data", cpuDataOut, 0);
      checkOutput("rst_cpu_stall", cpuStall, 0);
      @(posedge clock);
      #1 resetN = 1'b1;
`ifdef DCACHE_PERF_CNT_EN
      checkOutput("rst_hit_cnt", hitCnt, 0);
      checkOutput("rst_miss_cnt", missCnt, 0);
`endif

      // Cold load of 0x40, ack on the 10th cycle of the fetch: 1 + 10 + 1 stall cycles
      applyStimulus(1'b0, 32'h0000_0040, 32'h0, 10, fillA);
      checkOutput("cold_stall", stallCycles, 12);
      checkOutput("cold_fetches", nFetch, 1);
      checkOutput("cold_writebacks", nWb, 0);
      checkOutput("cold_fetch_addr", fetchAddr, 32'h0000_0040);
      checkOutput("cold_addr_stable", addrChanged, 0);
      checkOutput("cold_data", loadData, 32'hA000_0000);

      // Store hit to 0x44 then load it back, both with no stall
      applyStimulus(1'b1, 32'h0000_0044, 32'h1234_5678, 1, fillA);
      checkOutput("store_stall", stallCycles, 0);
      checkOutput("store_fetches", nFetch, 0);
      checkOutput("store_cpu_data", loadData, 0);
      applyStimulus(1'b0, 32'h0000_0044, 32'h0, 1, fillA);
      checkOutput("load44_stall", stallCycles, 0);
      checkOutput("load44_data", loadData, 32'h1234_5678);

      // Dirty conflict miss at 0x240 (index 2, tag 1): write-back of 0x40 then fetch
      applyStimulus(1'b0, 32'h0000_0240, 32'h0, 3, fillB);
      checkOutput("dirty_writebacks", nWb, 1);
      checkOutput("dirty_wb_addr", wbAddr, 32'h0000_0040);
      checkOutput("dirty_wb_word1", wbData[63:32], 32'h1234_5678);
      checkOutput("dirty_wb_word0", wbData[31:0], 32'hA000_0000);
      checkOutput("dirty_fetches", nFetch, 1);
      checkOutput("dirty_fetch_addr", fetchAddr, 32'h0000_0240);
      checkOutput("dirty_stall", stallCycles, 8);
      checkOutput("dirty_data", loadData, 32'hB000_0000);

      // Clean conflict eviction back to 0x40: fetch only
      applyStimulus(1'b0, 32'h0000_0040, 32'h0, 2, fillA);
      checkOutput("clean_writebacks", nWb, 0);
      checkOutput("clean_fetches", nFetch, 1);
      checkOutput("clean_fetch_addr", fetchAddr, 32'h0000_0040);
      checkOutput("clean_stall", stallCycles, 4);
      checkOutput("clean_data", loadData, 32'hA000_0000);
      applyStimulus(1'b0, 32'h0000_005C, 32'h0, 1, fillA);
      checkOutput("hit5c_stall", stallCycles, 0);
      checkOutput("hit5c_data", loadData, 32'hA000_0007);

      // Reset asserted mid-ALLOCATE, followed by a late ack
      cpuReq  = 1'b1;
      cpuWe   = 1'b0;
      cpuAddr = 32'h0000_0080;
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      checkOutput("alloc_enable", memEnable, 1);
      #2 resetN = 1'b0;
      #1;
      checkOutput("async_rst_enable", memEnable, 0);
      checkOutput("async_rst_addr", memAddr, 0);
      checkOutput("async_rst_stall", cpuStall, 1);
      cpuReq = 1'b0;
      @(posedge clock);
      #1 resetN = 1'b1;
      memAck    = 1'b1;
      memDataIn = {8{32'hEEEE_EEEE}};
      @(posedge clock);
      #1 memAck = 1'b0;
      @(negedge clock);
      checkOutput("late_ack_enable", memEnable, 0);
      checkOutput("late_ack_stall", cpuStall, 0);
`ifdef DCACHE_PERF_CNT_EN
      checkOutput("rst2_hit_cnt", hitCnt, 0);
      checkOutput("rst2_miss_cnt", missCnt, 0);
`endif
      @(posedge clock);
      #1;

      // After reset 0x40 misses again; then miss, hit, hit, miss
      applyStimulus(1'b0, 32'h0000_0040, 32'h0, 2, fillA);
      checkOutput("post_rst_stall", stallCycles, 4);
      checkOutput("post_rst_fetches", nFetch, 1);
      checkOutput("post_rst_writebacks", nWb, 0);
      checkOutput("post_rst_data", loadData, 32'hA000_0000);
      applyStimulus(1'b0, 32'h0000_0044, 32'h0, 1, fillA);
      checkOutput("hit44_stall", stallCycles, 0);
      checkOutput("hit44_data", loadData, 32'hA000_0001);
      applyStimulus(1'b0, 32'h0000_0048, 32'h0, 1, fillA);
      checkOutput("hit48_stall", stallCycles, 0);
      checkOutput("hit48_data", loadData, 32'hA000_0002);
      applyStimulus(1'b0, 32'h0000_0240, 32'h0, 1, fillB);
      checkOutput("miss240_stall", stallCycles, 3);
      checkOutput("miss240_writebacks", nWb, 0);
      checkOutput("miss240_fetch_addr", fetchAddr, 32'h0000_0240);
      checkOutput("miss240_data", loadData, 32'hB000_0000);
`ifdef DCACHE_PERF_CNT_EN
      checkOutput("perf_hit_cnt", hitCnt, 2);
      checkOutput("perf_miss_cnt", missCnt, 2);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
